multicycle_ctrl: RTL and testbench

Main control unit of the multicycle MIPS core; the core's datapath consumes every enable and select it produces. A Moore state machine steps each instruction through fetch, decode, execute, memory and writeback cycles. From the opcode held in the instruction register it produces the multiplexer selects, write enables and ALU control. It also decodes the ALU function, so the datapath needs no separate ALU decoder.

---
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle MIPS core, with built-in ALU function decode.
// Optional feature: define CTRL_BNE_EN to add the bne branch state BNEEX (code 12).
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] state,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t cur;
  logic   pcwrite;
  logic   branch;
  logic   branch_ne;

  // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= FETCH;
    end else begin
      case (cur)
        FETCH:   cur <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: cur <= MEMADR;
            OP_RTYPE:     cur <= RTYPEEX;
            OP_BEQ:       cur <= BEQEX;
            OP_ADDI:      cur <= ADDIEX;
            OP_J:         cur <= JEX;
`ifdef CTRL_BNE_EN
            OP_BNE:       cur <= BNEEX;
`endif
            default:      cur <= FETCH;
          endcase
        end
        MEMADR:  cur <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   cur <= MEMWB;
        RTYPEEX: cur <= RTYPEWB;
        ADDIEX:  cur <= ADDIWB;
        // Terminal states and the unreachable codes all return to FETCH.
        default: cur <= FETCH;
      endcase
    end
  end

  assign state = cur;

  function automatic logic [2:0] alu_decode(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b010;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    case (cur)
      FETCH:   begin alusrcb = 2'b01; irwrite = 1'b1; pcwrite = 1'b1; end
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; alucontrol = alu_decode(funct); end
      RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01; branch = 1'b1; end
      ADDIWB:  regwrite = 1'b1;
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
`ifdef CTRL_BNE_EN
      BNEEX:   begin alusrca = 1'b1; alucontrol = 3'b110; pcsrc = 2'b01; branch_ne = 1'b1; end
`endif
      default: ;
    endcase
    // Reset suppresses every write enable immediately, even mid-instruction.
    if (reset) begin
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcwrite  = 1'b0;
    end
  end

  assign pcen = ~reset & (pcwrite | (branch & zero) | (branch_ne & ~zero));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, hand-written corner sequences and random instructions.
// Handles both builds of the optional CTRL_BNE_EN feature.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] state;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .state(state),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       pcen;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cycles;
    string      name;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int seq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t dut_ctrl();
    return {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, alucontrol, pcsrc, pcen};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected outputs for a state, straight from the per-state output table.
  function automatic ctrl_t model(input int st, input logic [5:0] fn, input logic z, input logic rst);
    ctrl_t c;
    logic  pcw, br, brn;
    c = '0; pcw = 1'b0; br = 1'b0; brn = 1'b0;
    c.st = 4'(st);
    c.aluc = 3'b010;
    case (st)
      0:    begin c.alusrcb = 2'b01; c.irwrite = 1'b1; pcw = 1'b1; end
      1:    c.alusrcb = 2'b11;
      2, 9: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      3:    c.iord = 1'b1;
      4:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      5:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
      6:    begin c.alusrca = 1'b1; c.aluc = alu_of(fn); end
      7:    begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      8:    begin c.alusrca = 1'b1; c.aluc = 3'b110; c.pcsrc = 2'b01; br = 1'b1; end
      10:   c.regwrite = 1'b1;
      11:   begin c.pcsrc = 2'b10; pcw = 1'b1; end
`ifdef CTRL_BNE_EN
      12:   begin c.alusrca = 1'b1; c.aluc = 3'b110; c.pcsrc = 2'b01; brn = 1'b1; end
`endif
      default: ;
    endcase
    c.pcen = pcw | (br & z) | (brn & ~z);
    if (rst) begin
      c.irwrite = 1'b0; c.memwrite = 1'b0; c.regwrite = 1'b0; c.pcen = 1'b0;
    end
    return c;
  endfunction

  // State path of one instruction, from the transition rules.
  function automatic void build_seq(input logic [5:0] o);
    seq = {0, 1};
    case (o)
      6'h23: seq = {seq, 2, 3, 4};
      6'h2b: seq = {seq, 2, 5};
      6'h00: seq = {seq, 6, 7};
      6'h04: seq.push_back(8);
      6'h08: seq = {seq, 9, 10};
      6'h02: seq.push_back(11);
`ifdef CTRL_BNE_EN
      6'h05: seq.push_back(12);
`endif
      default: ;
    endcase
  endfunction

  // Entered at posedge+1 with the DUT in FETCH; inputs that must not matter are randomized.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] fn, input logic z, input string nm);
    build_seq(o);
    foreach (seq[i]) begin
      op    = (seq[i] == 1 || seq[i] == 2) ? o : 6'($urandom);
      funct = (seq[i] == 6) ? fn : 6'($urandom);
      zero  = (seq[i] == 8 || seq[i] == 12) ? z : 1'($urandom);
      #4;
      check(nm, 32'(dut_ctrl()), 32'(model(seq[i], fn, zero, 1'b0)));
      @(posedge clk); #1;
    end
    check({nm, "_back_to_fetch"}, 32'(state), 32'd0);
  endtask

  task automatic run_cpi(input logic [5:0] o, input logic [5:0] fn, input logic z,
                         input int exp_cycles, input string nm);
    int n;
    op = o; funct = fn; zero = z; n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (state != 4'd0 && n < 12);
    check({nm, "_cpi"}, 32'(n), 32'(exp_cycles));
  endtask

  vec_t vecs[$];
  logic [5:0] op_pool[8];
  logic [5:0] fn_pool[6];

  initial begin
    vecs = '{
      '{6'h23, 6'h20, 1'b0, 5, "lw"},
      '{6'h2b, 6'h20, 1'b0, 4, "sw"},
      '{6'h00, 6'h2a, 1'b0, 4, "rtype_slt"},
      '{6'h00, 6'h24, 1'b1, 4, "rtype_and"},
      '{6'h00, 6'h25, 1'b0, 4, "rtype_or"},
      '{6'h00, 6'h22, 1'b0, 4, "rtype_sub"},
      '{6'h00, 6'h3f, 1'b0, 4, "rtype_badfunct"},
      '{6'h08, 6'h00, 1'b0, 4, "addi"},
      '{6'h04, 6'h00, 1'b1, 3, "beq_taken"},
      '{6'h04, 6'h00, 1'b0, 3, "beq_not_taken"},
      '{6'h02, 6'h00, 1'b0, 3, "j"},
      '{6'h3f, 6'h00, 1'b0, 2, "undef_op"},
`ifdef CTRL_BNE_EN
      '{6'h05, 6'h00, 1'b0, 3, "bne_taken"},
      '{6'h05, 6'h00, 1'b1, 3, "bne_not_taken"}
`else
      '{6'h05, 6'h00, 1'b0, 2, "bne_undef"}
`endif
    };
    op_pool = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3f};
    fn_pool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h11};

    // Reset held for two edges: FETCH values with all writes suppressed.
    reset = 1'b1; op = 6'h23; funct = 6'h00; zero = 1'b0;
    #1 check("reset_initial", 32'(dut_ctrl()), 32'(model(0, 6'h00, 1'b0, 1'b1)));
    repeat (2) @(posedge clk);
    #1 check("reset_held", 32'(dut_ctrl()), 32'(model(0, 6'h00, 1'b0, 1'b1)));
    @(negedge clk) reset = 1'b0;
    #1 check("fetch_after_reset", 32'(dut_ctrl()), 32'(model(0, 6'h00, 1'b0, 1'b0)));
    @(posedge clk); #1;
    check("first_edge_decode", 32'(state), 32'd1);
    op = 6'h3f;
    @(posedge clk); #1;
    check("undef_to_fetch", 32'(state), 32'd0);

    // Vector table: measured cycles per instruction, then a cycle-by-cycle replay.
    foreach (vecs[i]) begin
      run_cpi(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].cycles, vecs[i].name);
      run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].name);
    end

    // sw interrupted by reset in MEMADR: state drops at once, memwrite never rises.
    op = 6'h2b;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sw_in_memadr", 32'(state), 32'd2);
    reset = 1'b1;
    #1 check("sw_reset_immediate", 32'(dut_ctrl()), 32'(model(0, 6'h00, zero, 1'b1)));
    @(posedge clk); #1;
    check("sw_reset_no_memwrite", 32'({state, memwrite}), 32'({4'd0, 1'b0}));
    @(negedge clk) reset = 1'b0;
    check("sw_reset_release_memwrite", 32'(memwrite), 32'd0);
    op = 6'h3f;
    @(posedge clk); #1;
    check("after_reset_decode", 32'(state), 32'd1);
    @(posedge clk); #1;
    check("after_reset_fetch", 32'(state), 32'd0);

    // Random instruction stream against the model.
    repeat (60) begin
      logic [5:0] o, fn;
      o  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 7)];
      fn = fn_pool[$urandom_range(0, 5)];
      run_instr(o, fn, 1'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
